// File: rtl/pilot_strip_if.sv
// Sample stream interface for pilot_strip: upstream sample input plus
// the forwarded data stream with valid/ready flow control.
interface pilot_strip_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] signal_in;
  logic              valid_in;
  logic              ready_out;
  logic              frame_start_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              data_last;

  modport master (
    output signal_in, valid_in, frame_start_in, data_ready,
    input  ready_out, data_out, data_valid, data_last
  );

  modport slave (
    input  signal_in, valid_in, frame_start_in, data_ready,
    output ready_out, data_out, data_valid, data_last
  );
endinterface

// File: rtl/pilot_strip.sv
// Pilot stripper: routes pilots to a side channel and forwards data through a 2-entry skid FIFO.
// Optional macro PILOT_CHECK_EN enables pilot comparison against pilot_value.
module pilot_strip #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 13
) (
  input  logic               clk,
  input  logic               rst,
  pilot_strip_if.slave       s,
  input  logic [CNT_W-1:0]   pilot_interval,
  input  logic [CNT_W-1:0]   frame_length,
  input  logic [DATA_W-1:0]  pilot_value,
  output logic [DATA_W-1:0]  pilot_out,
  output logic               pilot_valid,
  output logic               pilot_last,
  output logic               pilot_mismatch,
  output logic [15:0]        mismatch_count,
  output logic               error
);

  logic [CNT_W-1:0]  r_cnt_pilot;
  logic [CNT_W-1:0]  r_cnt_frame;
  logic [CNT_W-1:0]  w_cnt_pilot_nxt;
  logic [CNT_W-1:0]  w_cnt_frame_nxt;
  logic [CNT_W-1:0]  w_pos_p;
  logic [CNT_W-1:0]  w_pos_f;
  logic [CNT_W-1:0]  w_pi_m1;
  logic [CNT_W-1:0]  w_fl_m1;
  logic              w_accept;
  logic              w_cfg_ok;
  logic              w_is_pilot;
  logic              w_is_last;
  logic              w_sync_err;
  logic              w_push;
  logic              w_pop;

  logic [DATA_W-1:0] r_mem_d [2];
  logic              r_mem_l [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_fill;
  logic [1:0]        w_fill_nxt;
  logic              r_ready;

  logic [DATA_W-1:0] r_pilot_out;
  logic              r_pilot_valid;
  logic              r_pilot_last;
  logic              r_error;

  always_comb begin
    w_accept = s.valid_in & r_ready;
    w_cfg_ok = (pilot_interval >= CNT_W'(2)) && (frame_length != '0);
    // Minus-one terms only formed for a legal config so they never wrap.
    w_pi_m1  = w_cfg_ok ? pilot_interval - CNT_W'(1) : '0;
    w_fl_m1  = w_cfg_ok ? frame_length   - CNT_W'(1) : '0;
    w_pos_p  = s.frame_start_in ? '0 : r_cnt_pilot;
    w_pos_f  = s.frame_start_in ? '0 : r_cnt_frame;
    w_is_pilot = w_cfg_ok && (w_pos_p == '0);
    w_is_last  = w_cfg_ok && (w_pos_f == w_fl_m1);
    w_sync_err = w_accept && s.frame_start_in && (r_cnt_frame != '0);

    w_cnt_pilot_nxt = r_cnt_pilot;
    w_cnt_frame_nxt = r_cnt_frame;
    if (w_accept) begin
      if (!w_cfg_ok || w_is_last) begin
        w_cnt_pilot_nxt = '0;
        w_cnt_frame_nxt = '0;
      end else begin
        w_cnt_frame_nxt = w_pos_f + CNT_W'(1);
        w_cnt_pilot_nxt = (w_pos_p == w_pi_m1) ? '0 : w_pos_p + CNT_W'(1);
      end
    end

    w_push = w_accept && !w_is_pilot;
    w_pop  = (r_fill != 2'd0) && s.data_ready;
    w_fill_nxt = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_nxt = r_fill + 2'd1;
      2'b01:   w_fill_nxt = r_fill - 2'd1;
      default: w_fill_nxt = r_fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_pilot <= '0;
      r_cnt_frame <= '0;
      r_error     <= 1'b0;
    end else begin
      r_cnt_pilot <= w_cnt_pilot_nxt;
      r_cnt_frame <= w_cnt_frame_nxt;
      if (w_sync_err || (w_accept && !w_cfg_ok)) begin
        r_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pilot_out   <= '0;
      r_pilot_valid <= 1'b0;
      r_pilot_last  <= 1'b0;
    end else begin
      r_pilot_valid <= w_accept && w_is_pilot;
      r_pilot_last  <= w_accept && w_is_pilot && w_is_last;
      if (w_accept && w_is_pilot) begin
        r_pilot_out <= s.signal_in;
      end
    end
  end

  // Ready comes from the registered fill so data_ready never reaches ready_out combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem_d[i] <= '0;
        r_mem_l[i] <= 1'b0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_fill  <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_d[r_wptr] <= s.signal_in;
        r_mem_l[r_wptr] <= w_is_last;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_fill  <= w_fill_nxt;
      r_ready <= (w_fill_nxt != 2'd2);
    end
  end

  assign s.ready_out  = r_ready;
  assign s.data_valid = (r_fill != 2'd0);
  assign s.data_out   = r_mem_d[r_rptr];
  assign s.data_last  = r_mem_l[r_rptr] & (r_fill != 2'd0);

  assign pilot_out   = r_pilot_out;
  assign pilot_valid = r_pilot_valid;
  assign pilot_last  = r_pilot_last;
  assign error       = r_error;

`ifdef PILOT_CHECK_EN
  logic        r_mismatch;
  logic [15:0] r_mismatch_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch     <= 1'b0;
      r_mismatch_cnt <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_accept && w_is_pilot && (s.signal_in != pilot_value)) begin
        r_mismatch <= 1'b1;
        if (r_mismatch_cnt != '1) begin
          r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
        end
      end
    end
  end

  assign pilot_mismatch = r_mismatch;
  assign mismatch_count = r_mismatch_cnt;
`else
  logic w_unused_pilot_value;
  assign w_unused_pilot_value = ^pilot_value;
  assign pilot_mismatch = 1'b0;
  assign mismatch_count = '0;
`endif

endmodule
